// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - ALU_SEQ_WIDTH : default operand/result width
//   - OP_*          : 4-bit ALUControl opcode constants
//   - state_e       : controller FSM state encoding (IDLE/BUSY/DONE)
// Optional divider: enabled by defining ALU_SEQ_DIV_EN (see alu_seq.sv).
package alu_seq_pkg;

    localparam int ALU_SEQ_WIDTH = 32;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_JUMP = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SGT  = 4'd11;
    localparam logic [3:0] OP_CLZO = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;
    localparam logic [3:0] OP_SRL  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: iterative datapath shared by MUL (shift-add) and, when
// ALU_SEQ_DIV_EN is defined, DIVU/REMU (restoring division).
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   start_i         load operands and begin a WIDTH-step operation
//   div_i, rem_i    select divide / remainder (ignored without ALU_SEQ_DIV_EN)
//   a_i, b_i        operands (multiplicand/dividend, multiplier/divisor)
//   done_o          high during the cycle that performs the final step
//   result_o        value after the step in progress (valid when done_o)
//   div_zero_o      divide operation with a zero divisor
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_SEQ_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             rem_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             div_zero_o
);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    // acc: product accumulator / partial remainder
    // opa: multiplicand (shifts left) / dividend->quotient (shifts left)
    // opb: multiplier (shifts right) / divisor (static)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;

`ifdef ALU_SEQ_DIV_EN
    logic             div_q;
    logic             rem_sel_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
`else
    logic             unused_div_sel;
    assign unused_div_sel = div_i ^ rem_i;
`endif

    always_comb begin
        acc_d = opb_q[0] ? acc_q + opa_q : acc_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
`ifdef ALU_SEQ_DIV_EN
        // Bring the next dividend bit into the partial remainder and keep
        // the subtraction only if it does not go negative. A zero divisor
        // never goes negative, so the quotient fills with ones and the
        // remainder ends up equal to the dividend.
        shifted = {acc_q, opa_q[WIDTH-1]};
        trial   = shifted - {1'b0, opb_q};
        if (div_q) begin
            opb_d = opb_q;
            if (!trial[WIDTH]) begin
                acc_d = trial[WIDTH-1:0];
                opa_d = {opa_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted[WIDTH-1:0];
                opa_d = {opa_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_SEQ_DIV_EN
    assign result_o   = div_q ? (rem_sel_q ? acc_d : opa_d) : acc_d;
    assign div_zero_o = div_q && (opb_q == '0);
`else
    assign result_o   = acc_d;
    assign div_zero_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            acc_q  <= '0;
            opa_q  <= a_i;
            opb_q  <= b_i;
        end else if (busy_q) begin
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_DIV_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q     <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (start_i) begin
            div_q     <= div_i;
            rem_sel_q <= rem_i;
        end
    end
`endif

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request and result interface.
// Single-cycle ops are computed combinationally and registered at accept;
// MUL (and DIVU/REMU when ALU_SEQ_DIV_EN is defined) run WIDTH steps in
// alu_seq_iter. Without ALU_SEQ_DIV_EN, opcodes 13/14 are illegal.
// Ports:
//   Clk, Rst_n          clock, synchronous active-low reset
//   In_Valid/In_Ready   request handshake; ALUControl, A, B request payload
//   Out_Valid/Out_Ready result handshake; ALUResult, Zero, DivZero, Illegal
//   Dbg_State           current controller state (state_e encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The request payload is captured only on that edge. Out_Valid
// stays high and the result/flags stay stable until Out_Ready is seen.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_SEQ_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             DivZero,
    output logic             Illegal,
    output logic [1:0]       Dbg_State
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             div_zero_q, div_zero_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] sc_result;
    logic             sc_illegal;
    logic             is_multi;
    logic             is_div;
    logic             is_rem;
    logic [CNT_W:0]   lead_cnt;
    logic             lead_done;
    logic             accept;

    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic             iter_div_zero;

    // Opcode decode and single-cycle results.
    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        is_multi   = 1'b0;
        is_div     = 1'b0;
        is_rem     = 1'b0;
        lead_cnt   = '0;
        lead_done  = 1'b0;
        case (ALUControl)
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_ADD:  sc_result = A + B;
            OP_NOR:  sc_result = ~(A | B);
            OP_SUB:  sc_result = A - B;
            OP_SLT:  sc_result = WIDTH'($signed(A) < $signed(B));
            OP_JUMP: sc_result = '0;
            OP_MUL:  is_multi = 1'b1;
            OP_SLL:  sc_result = A << B[CNT_W-1:0];
            OP_SGT:  sc_result = WIDTH'($signed(A) > $signed(B));
            OP_CLZO: begin
                // B[0] selects the bit value being counted from the MSB down.
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (!lead_done) begin
                        if (A[i] == B[0]) begin
                            lead_cnt = lead_cnt + 1'b1;
                        end else begin
                            lead_done = 1'b1;
                        end
                    end
                end
                sc_result = WIDTH'(lead_cnt);
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                is_multi = 1'b1;
                is_div   = 1'b1;
            end
            OP_REMU: begin
                is_multi = 1'b1;
                is_div   = 1'b1;
                is_rem   = 1'b1;
            end
`endif
            OP_SRL:  sc_result = A >> B[CNT_W-1:0];
            default: sc_illegal = 1'b1;
        endcase
    end

    // Controller FSM. In_Ready is forced low during reset so nothing can be
    // accepted on a reset edge.
    always_comb begin
        state_d  = state_q;
        In_Ready = Rst_n && ((state_q == ST_IDLE) ||
                             (state_q == ST_DONE && Out_Ready));
        accept   = In_Valid && In_Ready;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_multi ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_d = is_multi ? ST_BUSY : ST_DONE;
                end else if (Out_Ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result register: loaded at accept for single-cycle ops, or from the
    // iterative datapath on its final step. A multi-cycle accept leaves the
    // old value in place; Out_Valid is low until the new result lands.
    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;
        if (accept && !is_multi) begin
            result_d   = sc_result;
            zero_d     = (sc_result == '0);
            div_zero_d = 1'b0;
            illegal_d  = sc_illegal;
        end else if (state_q == ST_BUSY && iter_done) begin
            result_d   = iter_result;
            zero_d     = (iter_result == '0);
            div_zero_d = iter_div_zero;
            illegal_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
        end
    end

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk_i      (Clk),
        .rst_ni     (Rst_n),
        .start_i    (accept && is_multi),
        .div_i      (is_div),
        .rem_i      (is_rem),
        .a_i        (A),
        .b_i        (B),
        .done_o     (iter_done),
        .result_o   (iter_result),
        .div_zero_o (iter_div_zero)
    );

    assign Out_Valid = (state_q == ST_DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign DivZero   = div_zero_q;
    assign Illegal   = illegal_q;
    assign Dbg_State = state_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and result width in bits (power of two, 8..64).
REQ-002 The block SHALL take parameter CNT_W, default $clog2(WIDTH), as the shift-amount and iteration-counter width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, named as follows: Clk  in  1  rising-edge clock.
REQ-004 Rst_n  in  1  synchronous active-low reset.
REQ-005 In_Valid  in  1  operation request valid.
REQ-006 In_Ready  out  1  block can accept a request this cycle.
REQ-007 ALUControl  in  4  opcode (codes in REQ-013).
REQ-008 A, B  in  WIDTH each  operands; shift amount = B[CNT_W-1:0]; CLO/CLZ select = B[0].
REQ-009 Out_Valid  out  1  result valid.
REQ-010 Out_Ready  in  1  consumer accepts result.
REQ-011 ALUResult  out  WIDTH  result; Zero  out  1  ALUResult==0; DivZero  out  1  divide/remainder by zero.
REQ-012 Illegal  out  1  opcode not implemented in this build.

Function
REQ-013 Opcodes SHALL be: 0 AND, 1 OR, 2 ADD, 3 NOR, 6 SUB, 7 SLT (signed), 8 JUMP (result 0), 9 MUL (low WIDTH bits), 10 SLL, 11 SGT (signed), 12 CLO (B[0]=1)/CLZ (B[0]=0), 13 DIVU, 14 REMU, 15 SRL; codes 4 and 5 SHALL be illegal.
REQ-014 The controller SHALL be an FSM with states IDLE, BUSY, DONE.
REQ-015 A request SHALL be accepted on a rising edge with In_Valid && In_Ready; the operands and opcode SHALL be captured at acceptance, and later input changes SHALL be ignored.
REQ-016 Single-cycle opcodes (0-3, 6-8, 10-12, 15, illegal) SHALL go IDLE->DONE, with Out_Valid high the cycle after acceptance (latency 1).
REQ-017 MUL (shift-add) and DIVU/REMU (restoring) SHALL go IDLE->BUSY for exactly WIDTH cycles, then ->DONE; latency SHALL be WIDTH+1.
REQ-018 In DONE, results and flags SHALL hold stable until Out_Ready; DONE->IDLE on Out_Ready without a new accept.
REQ-019 In_Ready SHALL equal (state==IDLE) || (state==DONE && Out_Ready), so back-to-back single-cycle ops sustain 1 result per cycle.
REQ-020 In_Ready SHALL be 0 in BUSY; In_Valid during BUSY SHALL be ignored.
REQ-021 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-022 SLT/SGT SHALL compare as two's complement and return 1 or 0.
REQ-023 CLZ/CLO SHALL return the count of leading zeros/ones of A, WIDTH when all bits match.
REQ-024 Divide by zero SHALL give quotient all-ones, remainder = A, and DivZero=1; otherwise DivZero=0.
REQ-025 Zero SHALL be registered together with ALUResult.
REQ-026 An illegal opcode SHALL give ALUResult=0, Zero=1, Illegal=1.

Reset
REQ-027 While Rst_n=0 at a rising edge, the FSM SHALL go to IDLE, and ALUResult, Zero, DivZero, Illegal, Out_Valid SHALL become 0.
REQ-028 A reset in BUSY or DONE SHALL abandon the operation with no result output.
REQ-029 In_Ready SHALL be 0 while Rst_n=0 and 1 in the first cycle after release.

Configuration
REQ-030 Macro ALU_SEQ_DIV_EN SHALL control the divider.
REQ-031 With ALU_SEQ_DIV_EN defined, DIVU/REMU SHALL behave per REQ-017/024.
REQ-032 Without ALU_SEQ_DIV_EN, there SHALL be no divider logic, and opcodes 13/14 SHALL be illegal per REQ-026, with latency 1 and DivZero always 0.

Structure
REQ-033 Package alu_seq_pkg SHALL hold the opcode constants, the FSM state encoding, and the default WIDTH.
REQ-034 Sub-module alu_seq_iter SHALL contain the shared shift-add/restoring-divide datapath and iteration counter, with start/done ports.
REQ-035 Single-cycle operations SHALL remain combinational in alu_seq ahead of the result register.

Verification
REQ-036 ADD A=0xFFFFFFFF, B=1, Out_Ready=1 -> next cycle Out_Valid=1, ALUResult=0, Zero=1.
REQ-037 SLT A=0x80000000, B=1 -> ALUResult=1; SGT with the same operands -> 0.
REQ-038 MUL A=7, B=6 -> In_Ready=0 for 32 cycles, then ALUResult=42 at cycle 33; B changed mid-op has no effect.
REQ-039 DIVU A=100, B=7 -> 14; REMU -> 2; DIVU A=5, B=0 -> 0xFFFFFFFF, DivZero=1; without ALU_SEQ_DIV_EN -> Illegal=1, ALUResult=0.
REQ-040 CLZ A=0x00010000 -> 15; CLO A=0xFFFFFFFF -> 32; Out_Ready=0 for 3 cycles -> result held, In_Ready=0.
REQ-041 Rst_n=0 mid-MUL (cycle 10) -> next cycle Out_Valid=0, ALUResult=0; after release, ADD 2+3 -> 5 at latency 1.
